// File: rtl/ccw_output.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ccw_output : counter-clockwise ring output port. Per-VC round-robin        |
// | arbitration, one-packet slot per VC, phase-aligned launch, hop decrement.  |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module ccw_output #(
  parameter int DATA_WIDTH = 64,
  parameter int HOP_MSB    = 55,
  parameter int HOP_LSB    = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  request_ccw_even,
  input  logic                  request_ccw_odd,
  input  logic                  request_pe_even,
  input  logic                  request_pe_odd,
  input  logic [DATA_WIDTH-1:0] data_in_ccw_even,
  input  logic [DATA_WIDTH-1:0] data_in_ccw_odd,
  input  logic [DATA_WIDTH-1:0] data_in_pe_even,
  input  logic [DATA_WIDTH-1:0] data_in_pe_odd,
  output logic                  grant_ccw_even,
  output logic                  grant_ccw_odd,
  output logic                  grant_pe_even,
  output logic                  grant_pe_odd,
  output logic                  ccwso,
  input  logic                  ccwro,
  output logic [DATA_WIDTH-1:0] ccwdo
);

  localparam int c_HOP_W = HOP_MSB - HOP_LSB + 1;

  // Index 0 is the even VC, index 1 the odd VC.
  logic [1:0]            w_req_ccw;
  logic [1:0]            w_req_pe;
  logic [1:0]            w_gnt_ccw;
  logic [1:0]            w_gnt_pe;
  logic [1:0]            w_launch;
  logic [DATA_WIDTH-1:0] w_din_ccw [2];
  logic [DATA_WIDTH-1:0] w_din_pe  [2];
  logic [DATA_WIDTH-1:0] w_slot    [2];

  assign w_req_ccw    = {request_ccw_odd, request_ccw_even};
  assign w_req_pe     = {request_pe_odd, request_pe_even};
  assign w_din_ccw[0] = data_in_ccw_even;
  assign w_din_ccw[1] = data_in_ccw_odd;
  assign w_din_pe[0]  = data_in_pe_even;
  assign w_din_pe[1]  = data_in_pe_odd;

  assign grant_ccw_even = w_gnt_ccw[0];
  assign grant_ccw_odd  = w_gnt_ccw[1];
  assign grant_pe_even  = w_gnt_pe[0];
  assign grant_pe_odd   = w_gnt_pe[1];

  // Saturating decrement of the hop field; every other bit passes through.
  function automatic logic [DATA_WIDTH-1:0] f_hop_dec(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = d;
    if (d[HOP_MSB:HOP_LSB] != '0) begin
      r[HOP_MSB:HOP_LSB] = d[HOP_MSB:HOP_LSB] - {{(c_HOP_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  genvar v;
  generate
    for (v = 0; v < 2; v++) begin : g_vc
      // Even slot launches at polarity=1 edges, odd slot at polarity=0 edges.
      localparam logic c_LAUNCH_POL = (v == 0) ? 1'b1 : 1'b0;

      logic                  r_full;
      logic                  r_last_pe;
      logic [DATA_WIDTH-1:0] r_slot;
      logic                  w_sel_ccw;
      logic                  w_sel_pe;

      assign w_sel_ccw    = w_req_ccw[v] & (~w_req_pe[v] | r_last_pe);
      assign w_sel_pe     = w_req_pe[v] & (~w_req_ccw[v] | ~r_last_pe);
      assign w_gnt_ccw[v] = ~rst & ~r_full & w_sel_ccw;
      assign w_gnt_pe[v]  = ~rst & ~r_full & w_sel_pe;
      assign w_launch[v]  = r_full & ccwro & (polarity == c_LAUNCH_POL);
      assign w_slot[v]    = r_slot;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_full    <= 1'b0;
          r_last_pe <= 1'b1;
          r_slot    <= '0;
        end else if (w_gnt_ccw[v]) begin
          r_slot    <= w_din_ccw[v];
          r_full    <= 1'b1;
          r_last_pe <= 1'b0;
        end else if (w_gnt_pe[v]) begin
          r_slot    <= w_din_pe[v];
          r_full    <= 1'b1;
          r_last_pe <= 1'b1;
        end else if (w_launch[v]) begin
          r_full    <= 1'b0;
        end
      end
    end
  endgenerate

  // Launch conditions are phase-exclusive, so at most one VC drives the link.
  always_ff @(posedge clk) begin
    if (rst) begin
      ccwso <= 1'b0;
      ccwdo <= '0;
    end else if (w_launch[1]) begin
      ccwso <= 1'b1;
      ccwdo <= f_hop_dec(w_slot[1]);
    end else if (w_launch[0]) begin
      ccwso <= 1'b1;
      ccwdo <= f_hop_dec(w_slot[0]);
    end else begin
      ccwso <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ccw_output.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ccw_output : directed self-checking bench for ccw_output.               |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_ccw_output;

  logic        clk = 1'b0;
  logic        rst;
  logic        polarity;
  logic        request_ccw_even, request_ccw_odd, request_pe_even, request_pe_odd;
  logic [63:0] data_in_ccw_even, data_in_ccw_odd, data_in_pe_even, data_in_pe_odd;
  logic        grant_ccw_even, grant_ccw_odd, grant_pe_even, grant_pe_odd;
  logic        ccwso;
  logic        ccwro;
  logic [63:0] ccwdo;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] c_A  = 64'h0003_0000_0000_00AA;
  localparam logic [63:0] c_AX = 64'h0002_0000_0000_00AA;
  localparam logic [63:0] c_C  = 64'hFF05_0000_0000_00C1;
  localparam logic [63:0] c_CX = 64'hFF04_0000_0000_00C1;
  localparam logic [63:0] c_P  = 64'h0007_0000_0000_00E1;
  localparam logic [63:0] c_PX = 64'h0006_0000_0000_00E1;
  localparam logic [63:0] c_B  = 64'h0010_0000_0000_00B0;
  localparam logic [63:0] c_BX = 64'h000F_0000_0000_00B0;
  localparam logic [63:0] c_D  = 64'h0003_0000_0000_0D0D;
  localparam logic [63:0] c_DX = 64'h0002_0000_0000_0D0D;
  localparam logic [63:0] c_E  = 64'h0009_0000_0000_0E0E;
  localparam logic [63:0] c_EX = 64'h0008_0000_0000_0E0E;
  localparam logic [63:0] c_F  = 64'hAB00_0000_1234_5678;
  localparam logic [63:0] c_G  = 64'h0001_0000_0000_0606;

  ccw_output #(.DATA_WIDTH(64), .HOP_MSB(55), .HOP_LSB(48)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .polarity         (polarity),
    .request_ccw_even (request_ccw_even),
    .request_ccw_odd  (request_ccw_odd),
    .request_pe_even  (request_pe_even),
    .request_pe_odd   (request_pe_odd),
    .data_in_ccw_even (data_in_ccw_even),
    .data_in_ccw_odd  (data_in_ccw_odd),
    .data_in_pe_even  (data_in_pe_even),
    .data_in_pe_odd   (data_in_pe_odd),
    .grant_ccw_even   (grant_ccw_even),
    .grant_ccw_odd    (grant_ccw_odd),
    .grant_pe_even    (grant_pe_even),
    .grant_pe_odd     (grant_pe_odd),
    .ccwso            (ccwso),
    .ccwro            (ccwro),
    .ccwdo            (ccwdo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; polarity flips just after each edge.
  task automatic tick();
    @(posedge clk);
    #1;
    polarity = ~polarity;
  endtask

  task automatic align(input logic p);
    if (polarity != p) tick();
  endtask

  initial begin
    rst = 1'b1; polarity = 1'b0; ccwro = 1'b1;
    request_ccw_even = 1'b1; request_ccw_odd = 1'b1;
    request_pe_even  = 1'b1; request_pe_odd  = 1'b1;
    data_in_ccw_even = '0; data_in_ccw_odd = '0;
    data_in_pe_even  = '0; data_in_pe_odd  = '0;

    // Reset with every request asserted
    #1;
    check_eq("rst_gce", grant_ccw_even, 1'b0);
    check_eq("rst_gco", grant_ccw_odd,  1'b0);
    check_eq("rst_gpe", grant_pe_even,  1'b0);
    check_eq("rst_gpo", grant_pe_odd,   1'b0);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      check_eq("rst_gce_h", grant_ccw_even, 1'b0);
      check_eq("rst_gpo_h", grant_pe_odd,   1'b0);
    end
    rst = 1'b0;
    #1;
    check_eq("post_rst_so", ccwso, 1'b0);
    check_eq("post_rst_do", ccwdo, 64'h0);
    check_eq("tie_gce", grant_ccw_even, 1'b1);
    check_eq("tie_gpe", grant_pe_even,  1'b0);
    check_eq("tie_gco", grant_ccw_odd,  1'b1);
    check_eq("tie_gpo", grant_pe_odd,   1'b0);
    request_ccw_even = 1'b0; request_ccw_odd = 1'b0;
    request_pe_even  = 1'b0; request_pe_odd  = 1'b0;

    // Single odd packet
    tick(); align(1'b0);
    request_ccw_odd = 1'b1; data_in_ccw_odd = c_A;
    #1;
    check_eq("odd_gnt", grant_ccw_odd, 1'b1);
    check_eq("odd_gpo", grant_pe_odd,  1'b0);
    tick(); request_ccw_odd = 1'b0; #1;
    check_eq("odd_so_w1", ccwso, 1'b0);
    tick(); #1;
    check_eq("odd_so_w2", ccwso, 1'b0);
    tick(); #1;
    check_eq("odd_pol", polarity, 1'b1);
    check_eq("odd_so", ccwso, 1'b1);
    check_eq("odd_do", ccwdo, c_AX);
    tick(); #1;
    check_eq("odd_so_end", ccwso, 1'b0);
    check_eq("odd_do_hold", ccwdo, c_AX);

    // Round-robin on the even VC
    tick(); align(1'b0);
    request_ccw_even = 1'b1; data_in_ccw_even = c_C;
    request_pe_even  = 1'b1; data_in_pe_even  = c_P;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      #1;
      check_eq("rr_gce", grant_ccw_even, (k % 2) == 0);
      check_eq("rr_gpe", grant_pe_even,  (k % 2) == 1);
      check_eq("rr_so",  ccwso, k > 0);
      if (k > 0) check_eq("rr_do", ccwdo, (k % 2) == 1 ? c_CX : c_PX);
      tick(); #1;
      check_eq("rr_gce_full", grant_ccw_even, 1'b0);
      check_eq("rr_gpe_full", grant_pe_even,  1'b0);
      check_eq("rr_so_gap",   ccwso, 1'b0);
    end
    tick();
    request_ccw_even = 1'b0; request_pe_even = 1'b0;
    #1;
    check_eq("rr_so_last", ccwso, 1'b1);
    check_eq("rr_do_last", ccwdo, c_PX);

    // Backpressure on the even VC
    tick(); align(1'b0);
    ccwro = 1'b0; request_ccw_even = 1'b1; data_in_ccw_even = c_B;
    #1;
    check_eq("bp_gnt0", grant_ccw_even, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      tick(); #1;
      check_eq("bp_gnt_held", grant_ccw_even, 1'b0);
      check_eq("bp_so_held",  ccwso, 1'b0);
    end
    tick(); ccwro = 1'b1; #1;
    check_eq("bp_so_pre", ccwso, 1'b0);
    check_eq("bp_gnt_pre", grant_ccw_even, 1'b0);
    tick(); #1;
    check_eq("bp_so",  ccwso, 1'b1);
    check_eq("bp_do",  ccwdo, c_BX);
    check_eq("bp_gnt_next", grant_ccw_even, 1'b1);
    request_ccw_even = 1'b0;

    // Both slots full: odd then even on consecutive cycles
    tick(); align(1'b1);
    request_pe_odd = 1'b1; data_in_pe_odd = c_D;
    request_pe_even = 1'b1; data_in_pe_even = c_E;
    #1;
    check_eq("il_gpo", grant_pe_odd,  1'b1);
    check_eq("il_gpe", grant_pe_even, 1'b1);
    check_eq("il_gco", grant_ccw_odd, 1'b0);
    tick(); request_pe_odd = 1'b0; request_pe_even = 1'b0; #1;
    check_eq("il_so0", ccwso, 1'b0);
    tick(); #1;
    check_eq("il_so_odd", ccwso, 1'b1);
    check_eq("il_do_odd", ccwdo, c_DX);
    tick(); #1;
    check_eq("il_so_even", ccwso, 1'b1);
    check_eq("il_do_even", ccwdo, c_EX);
    tick(); #1;
    check_eq("il_so_end", ccwso, 1'b0);

    // Zero hop passes unchanged; reset while the link is busy
    align(1'b1);
    request_ccw_odd = 1'b1; data_in_ccw_odd = c_F;
    request_pe_even = 1'b1; data_in_pe_even = c_G;
    #1;
    check_eq("hz_gco", grant_ccw_odd, 1'b1);
    check_eq("hz_gpe", grant_pe_even, 1'b1);
    tick(); request_ccw_odd = 1'b0; request_pe_even = 1'b0; #1;
    check_eq("hz_so0", ccwso, 1'b0);
    tick(); #1;
    check_eq("hz_so", ccwso, 1'b1);
    check_eq("hz_do", ccwdo, c_F);
    rst = 1'b1;
    tick(); #1;
    check_eq("mr_so", ccwso, 1'b0);
    check_eq("mr_do", ccwdo, 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check_eq("mr_no_launch", ccwso, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
